// File: rtl/bus_tracer.sv
// bus_tracer: snoops the 6502 bus on each CPU clock falling edge, packs a
// 4-byte record {ADDR_HI, ADDR_LO, DATA, FLAGS}, queues it in a FIFO and
// streams it out as back-to-back 8N1 UART bytes on the board clock.
// FLAGS = {write, drop, seq[5:0]}; drop marks the first record accepted
// after one or more records were lost to a full FIFO.
// Optional feature: define BUS_TRACER_SYNC_EN to prefix every record with
// the sync byte 0xA5 (5 bytes per record).
module bus_tracer #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                     CLK,
    input  logic                     R,
    input  logic                     cpu_clk_in,
    input  logic [15:0]              addr_bus,
    input  logic [7:0]               data_out,
    input  logic [7:0]               data_in,
    input  logic                     data_write,
    input  logic                     trace_en,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [15:0] BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

`ifdef BUS_TRACER_SYNC_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    // Byte idx of a record in wire order (sync byte first when enabled).
    function automatic logic [7:0] record_byte(input logic [31:0] rec,
                                               input logic [2:0]  idx);
`ifdef BUS_TRACER_SYNC_EN
        case (idx)
            3'd0:    return 8'hA5;
            3'd1:    return rec[31:24];
            3'd2:    return rec[23:16];
            3'd3:    return rec[15:8];
            default: return rec[7:0];
        endcase
`else
        case (idx)
            3'd0:    return rec[31:24];
            3'd1:    return rec[23:16];
            3'd2:    return rec[15:8];
            default: return rec[7:0];
        endcase
`endif
    endfunction

    // Capture side state
    logic            cpu_clk_q;
    logic [5:0]      seq_q;
    logic            drop_pending_q;
    logic            overflow_q;

    // FIFO state
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;

    // Transmitter state
    tx_state_e       state_q;
    logic [15:0]     baud_q;
    logic [2:0]      bit_q;
    logic [2:0]      byte_q;
    logic [7:0]      shift_q;
    logic [31:0]     hold_q;
    logic            tx_q;

    logic            capture;
    logic            fifo_empty;
    logic            fifo_full;
    logic            bit_done;
    logic            last_byte;
    logic            pop;
    logic            accept;
    logic [31:0]     new_rec;
    logic [31:0]     head_rec;

    assign capture    = trace_en & ~cpu_clk_in & cpu_clk_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_LEVEL);
    assign bit_done   = (baud_q == BAUD_LAST);
    assign last_byte  = (byte_q == LAST_BYTE);

    // The head is taken when the line is idle, or at the very end of the last
    // stop bit so the next record follows with no idle gap.
    assign pop = ~fifo_empty &
                 ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_done & last_byte));

    // A pop in the same cycle frees a slot, so a capture into a full FIFO survives.
    assign accept = capture & (~fifo_full | pop);

    assign new_rec  = {addr_bus, (data_write ? data_out : data_in),
                       data_write, drop_pending_q, seq_q};
    assign head_rec = mem_q[rd_ptr_q];

    assign tx         = tx_q;
    assign busy       = ~fifo_empty | (state_q != S_IDLE);
    assign overflow   = overflow_q;
    assign fifo_level = count_q;

    // Registered copy of the CPU clock level for falling-edge detection.
    always_ff @(posedge CLK or negedge R) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values.
        if (!R) begin
            cpu_clk_q <= 1'b0;
        end else begin
            cpu_clk_q <= cpu_clk_in;
        end
    end

    // Sequence tag, pending-drop marker and sticky overflow flag.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            seq_q          <= '0;
            drop_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else if (accept) begin
            seq_q          <= seq_q + 6'd1;
            drop_pending_q <= 1'b0;
        end else if (capture) begin
            drop_pending_q <= 1'b1;
            overflow_q     <= 1'b1;
        end
    end

    // FIFO storage array.
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset; only pointers and level define validity.
        if (accept) begin
            mem_q[wr_ptr_q] <= new_rec;
        end
    end

    // FIFO pointers and level; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // UART transmitter FSM with registered line output.
    always_ff @(posedge CLK or negedge R) begin
        // NOTE: tx is part of the async reset so the line returns high immediately.
        if (!R) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
        end else if (pop) begin
            hold_q  <= head_rec;
            byte_q  <= '0;
            shift_q <= record_byte(head_rec, 3'd0);
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                end
                S_START: begin
                    if (bit_done) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        baud_q <= '0;
                        if (!last_byte) begin
                            byte_q  <= byte_q + 3'd1;
                            shift_q <= record_byte(hold_q, byte_q + 3'd1);
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_tracer.sv
// Directed bench for bus_tracer (CLKS_PER_BIT=4, DEPTH=2). A passive UART
// receiver collects bytes from tx into a queue; the main sequence drives CPU
// bus cycles and compares level/flags/bytes against hand-computed values.
module tb_bus_tracer;

    localparam int C = 4;
    localparam int D = 2;
`ifdef BUS_TRACER_SYNC_EN
    localparam int REC_CYCLES = 50 * C;
`else
    localparam int REC_CYCLES = 40 * C;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_clk_in;
    logic [15:0] addr_bus;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        data_write;
    logic        trace_en;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [$clog2(D):0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    bus_tracer #(
        .CLKS_PER_BIT (C),
        .DEPTH        (D)
    ) dut (
        .CLK        (clk),
        .R          (rst_n),
        .cpu_clk_in (cpu_clk_in),
        .addr_bus   (addr_bus),
        .data_out   (data_out),
        .data_in    (data_in),
        .data_write (data_write),
        .trace_en   (trace_en),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Passive 8N1 receiver sampling mid-bit on the falling clock edge.
    logic [7:0] rx_q[$];
    int         rx_frame_err = 0;
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_shift = 8'h00;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == C/2 + 9*C) begin
                if (tx !== 1'b1) rx_frame_err++;
                rx_q.push_back(rx_shift);
                rx_active = 1'b0;
            end else if (rx_cnt >= C/2 + C && ((rx_cnt - C/2) % C) == 0) begin
                rx_shift = {tx, rx_shift[7:1]};
            end
        end
    end

    // Time limit for the whole run.
    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU cycle: high for one CLK, then low with the bus valid (capture cycle).
    // Returns in the cycle after the capture cycle.
    task automatic capture(input logic [15:0] a, input logic [7:0] dout,
                           input logic [7:0] din, input logic wr);
        cpu_clk_in = 1'b1;
        tick();
        cpu_clk_in = 1'b0;
        addr_bus   = a;
        data_out   = dout;
        data_in    = din;
        data_write = wr;
        tick();
    endtask

    task automatic wait_idle(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        check({tag, ".idle"}, busy, 1'b0);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        if (rx_q.size() == 0) b = 8'hxx;
        else b = rx_q.pop_front();
        check(tag, b, exp);
    endtask

    task automatic expect_record(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                                 input logic [7:0] d, input logic [7:0] f);
`ifdef BUS_TRACER_SYNC_EN
        expect_byte({tag, ".sync"}, 8'hA5);
`endif
        expect_byte({tag, ".addr_hi"}, hi);
        expect_byte({tag, ".addr_lo"}, lo);
        expect_byte({tag, ".data"}, d);
        expect_byte({tag, ".flags"}, f);
    endtask

    initial begin
        int cyc;

        rst_n      = 1'b0;
        cpu_clk_in = 1'b0;
        addr_bus   = '0;
        data_out   = '0;
        data_in    = '0;
        data_write = 1'b0;
        trace_en   = 1'b1;
        repeat (3) tick();

        // Reset state
        check("reset.tx", tx, 1'b1);
        check("reset.busy", busy, 1'b0);
        check("reset.overflow", overflow, 1'b0);
        check("reset.level", fifo_level, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single read capture: level at N+1, start bit at N+2, 40 bit times busy
        capture(16'hFFFC, 8'h00, 8'h00, 1'b0);
        check("single.level_n1", fifo_level, 1);
        check("single.busy_n1", busy, 1'b1);
        check("single.tx_n1", tx, 1'b1);
        tick();
        check("single.start_n2", tx, 1'b0);
        check("single.level_n2", fifo_level, 0);
        wait_idle("single", 1000, cyc);
        check("single.busy_len", cyc, REC_CYCLES);
        expect_record("single", 8'hFF, 8'hFC, 8'h00, 8'h00);
        check("single.no_extra", rx_q.size(), 0);

        // Write cycle: DATA from data_out, FLAGS = 0x80 | seq(1)
        capture(16'h0200, 8'h5A, 8'h33, 1'b1);
        wait_idle("write", 1000, cyc);
        expect_record("write", 8'h02, 8'h00, 8'h5A, 8'h81);

        // Overflow: 5 captures every 2 CLK into DEPTH=2 -> 3 kept, 2 dropped
        for (int i = 0; i < 5; i++) begin
            capture(16'h1000 + 16'(i), 8'h00, 8'h10 + 8'(i), 1'b0);
        end
        check("ovf.level", fifo_level, 2);
        check("ovf.flag", overflow, 1'b1);
        wait_idle("ovf", 2000, cyc);
        expect_record("ovf.r0", 8'h10, 8'h00, 8'h10, 8'h02);
        expect_record("ovf.r1", 8'h10, 8'h01, 8'h11, 8'h03);
        expect_record("ovf.r2", 8'h10, 8'h02, 8'h12, 8'h04);
        check("ovf.no_extra", rx_q.size(), 0);
        check("ovf.level_drained", fifo_level, 0);
        capture(16'h2000, 8'h00, 8'h20, 1'b0);
        wait_idle("ovf.next", 1000, cyc);
        expect_record("ovf.next", 8'h20, 8'h00, 8'h20, 8'h45);
        capture(16'h2001, 8'h00, 8'h21, 1'b0);
        wait_idle("ovf.after", 1000, cyc);
        expect_record("ovf.after", 8'h20, 8'h01, 8'h21, 8'h06);
        check("ovf.sticky", overflow, 1'b1);

        // Reset during DATA bit 3 of the first byte with one record still queued
        capture(16'h3456, 8'h00, 8'h77, 1'b0);
        capture(16'h3457, 8'h00, 8'h78, 1'b0);
        repeat (16) tick();
`ifdef BUS_TRACER_SYNC_EN
        check("rst.bit3_low", tx, 1'b0);   // bit3 of 0xA5 is 0
`else
        check("rst.bit3_low", tx, 1'b0);   // bit3 of 0x34 is 0
`endif
        check("rst.level_before", fifo_level, 1);
        rst_n = 1'b0;
        #1;
        check("rst.tx_immediate", tx, 1'b1);
        check("rst.busy", busy, 1'b0);
        check("rst.level", fifo_level, 0);
        check("rst.overflow", overflow, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        rx_q.delete();
        tick();
        check("rst.level_after", fifo_level, 0);
        check("rst.busy_after", busy, 1'b0);

        // Sequence wrap: 65 paced captures give seq 0..63, 0
        for (int i = 0; i < 65; i++) begin
            capture(16'h4000 + 16'(i), 8'h00, 8'(i), 1'b0);
            wait_idle($sformatf("seq%0d", i), 1000, cyc);
            expect_record($sformatf("seq%0d", i), 8'h40, 8'(i), 8'(i), 8'(i % 64));
        end

        // Capture disabled: 10 CPU cycles leave everything idle
        trace_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            capture(16'h5000 + 16'(i), 8'h00, 8'h55, 1'b0);
            check($sformatf("off%0d.level", i), fifo_level, 0);
            check($sformatf("off%0d.tx", i), tx, 1'b1);
        end
        repeat (4) tick();
        check("off.busy", busy, 1'b0);
        check("off.no_bytes", rx_q.size(), 0);
        trace_en = 1'b1;

        check("rx.framing", rx_frame_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_tracer.md
# bus_tracer

Downstream debug stage for the 6502 core. It snoops the CPU bus once per CPU clock cycle and packs address, data, direction and a sequence tag into a 4-byte record. Records are queued in a FIFO and streamed out as 8N1 UART bytes, clocked by the 12 MHz board clock. This gives an off-board instruction/bus trace in place of the 8-LED opcode display.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104: CLK cycles per UART bit (12 MHz / 115200); legal 4..65535.
- `DEPTH`, 16: FIFO depth in records; power of two, 2..64.

Ports:
- `CLK` in 1: 12 MHz board clock; all logic on posedge.
- `R` in 1: reset, asynchronous, active-low.
- `cpu_clk_in` in 1: CPU clock level (divided clock), generated in `CLK` domain, no synchronizer.
- `addr_bus` in 16: CPU address bus.
- `data_out` in 8: CPU write data.
- `data_in` in 8: CPU read data.
- `data_write` in 1: 1 = CPU write cycle.
- `trace_en` in 1: capture enable.
- `tx` out 1: UART serial output, idle high.
- `busy` out 1: FIFO non-empty or a byte in flight.
- `overflow` out 1: sticky, at least one record dropped since reset.
- `fifo_level` out clog2(DEPTH)+1: records currently queued.

## Operation
- Capture event: CLK cycle with `cpu_clk_in`=0 and its 1-cycle registered copy =1 (CPU clock falling edge) and `trace_en`=1. Bus inputs are sampled in that same cycle.
- Record bytes, sent in order:
  - ADDR_HI = `addr_bus[15:8]`.
  - ADDR_LO = `addr_bus[7:0]`.
  - DATA = `data_out` if `data_write` else `data_in`.
  - FLAGS = {`data_write`, drop, seq[5:0]}.
- seq: 6-bit counter, increments per accepted record; wraps 63→0; reset 0. Dropped records do not consume a seq value.
- FIFO full at capture event:
  - Record is dropped.
  - `drop_pending` and `overflow` are set.
  - The next accepted record carries drop=1, and `drop_pending` clears.
- Pop: the head record moves into a 32-bit holding register when the transmitter is idle and the FIFO is non-empty.
- Pop and capture in the same cycle with FIFO full: the pop frees a slot first, so the capture is accepted and the level is unchanged.
- Transmitter states: IDLE → START → DATA(8 bits, LSB first) → STOP → next byte START, or IDLE once all 4 bytes are sent and the FIFO is empty.
  - Bytes are sent back to back with no idle gap between bytes or records.
- `trace_en` deassert: stops new captures only; queued records still drain.

## Timing
- Reset (async assert): `tx`=1, `busy`=0, `overflow`=0, `fifo_level`=0, seq=0, FIFO empty, transmitter IDLE.
  - Reset mid-frame: `tx` goes high immediately; all queued data is lost.
- Capture at cycle N: `fifo_level` increments at N+1.
- If idle at capture: pop at N+1, and the start bit drives `tx`=0 from N+2.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. One byte = 10×`CLKS_PER_BIT` cycles; one record = 40×`CLKS_PER_BIT` cycles.
- `busy`: high from N+1 until the last cycle of the final stop bit (inclusive); low the next cycle.
- Capture rate: max one per CPU cycle (every 2 CLK at minimum divide). The FIFO absorbs bursts; sustained rate above the UART rate overflows by design.

## Configuration
- `BUS_TRACER_SYNC_EN` defined:
  - Each record is prefixed by sync byte 0xA5, giving 5 bytes and 50×`CLKS_PER_BIT` cycles per record.
  - Start latency is unchanged; the first byte on the wire is 0xA5.
- Undefined: 4-byte records as above, no sync byte.

## Test plan
- Single capture, `CLKS_PER_BIT`=4: `addr_bus`=0xFFFC, `data_in`=0x00, `data_write`=0, one CPU falling edge → `tx` emits 0xFF, 0xFC, 0x00, 0x00; start bit at N+2; `busy` drops after 160 cycles.
- Write cycle: `addr_bus`=0x0200, `data_out`=0x5A, `data_in`=0x33, `data_write`=1 → bytes 0x02, 0x00, 0x5A, 0x80+seq.
- Overflow, `DEPTH`=2, `CLKS_PER_BIT`=4:
  - 5 back-to-back captures; expect 3 sent (1 popped, 2 queued) and 2 dropped.
  - `overflow`=1 and stays high.
  - The next accepted record has FLAGS bit6=1; the one after has bit6=0.
- Seq wrap: 65 captures with slow bus pacing → seq goes 0..63, 0; the last FLAGS byte low bits = 0x00.
- Reset mid-byte: assert `R`=0 during DATA bit 3 → `tx`=1 in the same cycle; after release `fifo_level`=0, `busy`=0, and the next record has seq=0.
- `trace_en`=0 during 10 CPU cycles → no level change, `tx` stays high. With `BUS_TRACER_SYNC_EN`, one capture → 0xA5 precedes the record.
